muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request a new MULT/MULTU/DIV/DIVU from decode.
REQ-004 SHALL have ports: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: rs_val  in  32  first operand (multiplicand or dividend).
REQ-006 SHALL have ports: rt_val  in  32  second operand (multiplier or divisor).
REQ-007 SHALL have ports: mf_req  in  1  MFHI/MFLO read request.
REQ-008 SHALL have ports: mf_sel  in  1  0 = LO, 1 = HI.
REQ-009 SHALL have ports: busy  out  1  operation in progress.
REQ-010 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: stall  out  1  hold decode/issue.
REQ-012 SHALL have ports: hi, lo  out  32 each  registered HI/LO.
REQ-013 SHALL have ports: mf_data  out  32  combinational mf_sel ? hi : lo.

Function
REQ-014 SHALL implement FSM states IDLE, PREP, RUN, FINISH.
REQ-015 SHALL accept start only in IDLE or FINISH; cycle N is the cycle in which start=1 is sampled, and op/rs_val/rt_val SHALL be latched at the end of N.
REQ-016 SHALL spend exactly one cycle in PREP (N+1), taking absolute values for the signed ops and recording the result signs.
REQ-017 SHALL spend k cycles in RUN (N+2..N+1+k), one iteration per cycle, with k=32 by default.
REQ-018 SHALL multiply by left-shifting a 64-bit multiplicand and right-shifting the multiplier, adding to the product when the multiplier LSB is 1.
REQ-019 SHALL divide by restoring division, one quotient bit per iteration.
REQ-020 SHALL be in FINISH at cycle N+2+k, with done=1, sign-corrected hi/lo visible, and busy=0.
REQ-021 SHALL assert busy in PREP and RUN only.
REQ-022 SHALL produce, for multiply, {hi,lo} = the full 64-bit product, signed for MULT and unsigned for MULTU.
REQ-023 SHALL produce, for divide, lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-024 SHALL, on divide by zero (signed or unsigned), give lo=0xFFFFFFFF and hi=rs_val, with no exception.
REQ-025 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give lo=0x80000000 and hi=0.
REQ-026 SHALL ignore start while busy (no queueing) and keep hi/lo unchanged.
REQ-027 SHALL drive stall = busy & (mf_req | start).
REQ-028 SHALL, when mf_req arrives in FINISH, return the new result with no stall.
REQ-029 SHALL update hi/lo only at the RUN→FINISH transition.
REQ-030 SHALL hold hi/lo and keep mf_data valid in IDLE.

Reset
REQ-031 SHALL, on reset, enter IDLE and clear hi, lo, busy, done, stall and all iteration registers by the next edge.
REQ-032 SHALL, if reset occurs mid-operation, abandon the operation with no done pulse and leave hi/lo at 0.
REQ-033 SHALL give reset priority over a simultaneous start.

Configuration
REQ-034 SHALL support the macro MULDIV_EARLY_OUT_EN.
REQ-035 SHALL, when MULDIV_EARLY_OUT_EN is defined, end multiply RUN after the iteration in which the remaining multiplier becomes zero, with a minimum of one iteration, so that k = max(1, index of highest set bit of |rt_val| + 1).
REQ-036 SHALL, when MULDIV_EARLY_OUT_EN is defined, keep divide fixed at k=32.
REQ-037 SHALL, when MULDIV_EARLY_OUT_EN is undefined, use k=32 for all ops.
REQ-038 SHALL, with or without MULDIV_EARLY_OUT_EN, produce identical results.

Structure
REQ-039 SHALL place in shared package muldiv_pkg: the op encoding enum (MULT/MULTU/DIV/DIVU), the FSM state enum, ITER_COUNT=32, and DIV0_QUOTIENT=32'hFFFFFFFF.
REQ-040 SHALL use one sub-module, muldiv_signfix: a combinational 32/64-bit conditional two's-complement negate, used in both PREP and FINISH.

Verification
REQ-041 SHALL cover: MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done at N+34 (macro off).
REQ-042 SHALL cover: MULT −3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-043 SHALL cover: DIVU 7/0 → lo=0xFFFFFFFF, hi=0x00000007, done at N+34.
REQ-044 SHALL cover: mf_req with mf_sel=1 at N+5 → stall=1 through N+33, stall=0 at N+34 with mf_data = new hi; start at N+10 ignored.
REQ-045 SHALL cover: reset at N+10 → busy=0, hi=lo=0 at N+11, no done pulse; a new start is accepted at N+11.
REQ-046 SHALL cover: with MULDIV_EARLY_OUT_EN, MULTU 5×3 → done at N+4, lo=15, hi=0; DIVU 100/7 → done at N+34, lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/MULTU/DIV/DIVU sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FINISH
  } state_e;

  localparam int unsigned ITER_COUNT    = 32;
  localparam int unsigned CNT_W         = 6;
  localparam int unsigned DATA_W        = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand abs() and result sign correction.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res_c
);

  always_comb begin
    res_c = neg ? ((~val) + W'(1)) : val;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers and decode stall.
// Optional build macro MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_W-1:0]     rs_q, rs_d, rt_q, rt_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [DATA_W-1:0]     rs_abs_c, rt_abs_c;
  logic [2*DATA_W-1:0]   mul_acc_n, mul_mcand_n, prod_fix_c;
  logic [DATA_W-1:0]     mul_mplier_n;
  logic [DATA_W:0]       div_sh;
  logic                  div_ge;
  logic [DATA_W-1:0]     div_rem_n, div_quo_n, quo_fix_c, rem_fix_c;
  logic                  run_last;
  logic                  rs_neg_c, rt_neg_c;

  assign rs_neg_c = op_is_signed(op_q) & rs_q[DATA_W-1];
  assign rt_neg_c = op_is_signed(op_q) & rt_q[DATA_W-1];

  muldiv_signfix #(.W(DATA_W))   u_fix_rs   (.val(rs_q),         .neg(rs_neg_c), .res_c(rs_abs_c));
  muldiv_signfix #(.W(DATA_W))   u_fix_rt   (.val(rt_q),         .neg(rt_neg_c), .res_c(rt_abs_c));
  muldiv_signfix #(.W(2*DATA_W)) u_fix_prod (.val(mul_acc_n),    .neg(neg_lo_q), .res_c(prod_fix_c));
  muldiv_signfix #(.W(DATA_W))   u_fix_quo  (.val(div_quo_n),    .neg(neg_lo_q), .res_c(quo_fix_c));
  muldiv_signfix #(.W(DATA_W))   u_fix_rem  (.val(div_rem_n),    .neg(neg_hi_q), .res_c(rem_fix_c));

  // One shift-add multiply step and one restoring divide step, evaluated every RUN cycle.
  // Divide reuses mcand_q[31:0] as dividend/quotient shifter, acc_q[31:0] as remainder, mplier_q as divisor.
  always_comb begin
    mul_acc_n    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_mcand_n  = mcand_q << 1;
    mul_mplier_n = mplier_q >> 1;
    div_sh       = {acc_q[DATA_W-1:0], mcand_q[DATA_W-1]};
    div_ge       = (div_sh >= {1'b0, mplier_q});
    div_rem_n    = div_ge ? DATA_W'(div_sh - {1'b0, mplier_q}) : div_sh[DATA_W-1:0];
    div_quo_n    = {mcand_q[DATA_W-2:0], div_ge};
    run_last     = (cnt_q == CNT_W'(ITER_COUNT - 1)) ||
                   (EARLY_OUT && !op_is_div(op_q) && (mul_mplier_n == '0));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d = ST_PREP;
          op_d    = op_e'(op);
          rs_d    = rs_val;
          rt_d    = rt_val;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        mcand_d  = {{DATA_W{1'b0}}, rs_abs_c};
        mplier_d = rt_abs_c;
        acc_d    = '0;
        cnt_d    = '0;
        neg_lo_d = op_is_signed(op_q) & (rs_q[DATA_W-1] ^ rt_q[DATA_W-1]);
        neg_hi_d = rs_neg_c;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_is_div(op_q)) begin
          mcand_d = {{DATA_W{1'b0}}, div_quo_n};
          acc_d   = {{DATA_W{1'b0}}, div_rem_n};
        end else begin
          acc_d    = mul_acc_n;
          mcand_d  = mul_mcand_n;
          mplier_d = mul_mplier_n;
        end
        if (run_last) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          if (!op_is_div(op_q)) begin
            {hi_d, lo_d} = prod_fix_c;
          end else if (rt_q == '0) begin
            hi_d = rs_q;
            lo_d = DIV0_QUOTIENT;
          end else begin
            hi_d = rem_fix_c;
            lo_d = quo_fix_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      rs_q     <= '0;
      rt_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = busy_q & (mf_req | start);
  assign mf_data = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, decoupled done monitor.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, mf_req, mf_sel;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, stall;
  logic [31:0] hi, lo, mf_data;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
    string       nm;
  } exp_t;

  exp_t sb[$];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .mf_sel(mf_sel),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Multiply latency depends on the build; divides are always 32 iterations.
  function automatic int k_of(input int k_eo);
`ifdef MULDIV_EARLY_OUT_EN
    return k_eo;
`else
    return (k_eo > 0) ? 32 : 32;
`endif
  endfunction

  // Called at a negedge in cycle N; returns at the negedge of cycle N+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int k,
                       input string nm, input bit push, output int unsigned n);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    n = cyc;
    if (push) sb.push_back('{eh, el, n + 2 + k, nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int k);
    int unsigned n;
    issue(o, a, b, eh, el, k, nm, 1'b1, n);
    check({nm, "_busy_prep"}, 64'(busy), 64'd1);
    repeat (k + 1) @(negedge clk);
    check({nm, "_busy_finish"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({nm, "_done_pulse_end"}, 64'(done), 64'd0);
    check({nm, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
          check({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
          check({e.nm, "_done_cycle"}, 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    int unsigned n;
    int          bad;
    reset = 1'b1; start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
    mf_req = 1'b0; mf_sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mf_data", 64'(mf_data), 64'd0);

    run_vec("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, k_of(32));
    run_vec("mult_neg",     2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, k_of(3));
    run_vec("div_neg",      2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    run_vec("divu_zero",    2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 32);
    run_vec("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32);
    run_vec("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32);
    run_vec("multu_small",  2'b01, 32'd5,         32'd3,         32'd0,         32'd15,        k_of(2));
    run_vec("divu_small",   2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        32);
    run_vec("mult_minsq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, k_of(32));
    run_vec("mult_zero",    2'b00, 32'd7,         32'd0,         32'd0,         32'd0,         k_of(1));
    run_vec("div_negdvsr",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 32);
    run_vec("mult_negneg",  2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd0,         32'd42,        k_of(3));

    // MFHI held off until the result lands; a start mid-operation is dropped.
    issue(2'b11, 32'h1234_5678, 32'h0000_0100, 32'h0000_0078, 32'h0012_3456, 32, "divu_stall", 1'b1, n);
    repeat (4) @(negedge clk);
    mf_req = 1'b1; mf_sel = 1'b1;
    bad = 0;
    while (cyc <= n + 33) begin
      start = (cyc == n + 10);
      op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
      #1;
      if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    check("stall_held_cycles_bad", 64'(bad), 64'd0);
    check("stall_finish", 64'(stall), 64'd0);
    check("mf_data_hi_finish", 64'(mf_data), 64'h78);
    mf_sel = 1'b0;
    #1;
    check("mf_data_lo_finish", 64'(mf_data), 64'h0012_3456);
    mf_req = 1'b0;
    @(negedge clk);
    check("stall_test_drained", 64'(sb.size()), 64'd0);
    check("stall_test_idle_busy", 64'(busy), 64'd0);

    // Reset mid-operation, coincident with a start, then a fresh start right after.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32, "abandoned", 1'b0, n);
    repeat (9) @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    run_vec("divu_after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32);

    // HI/LO stay readable while idle.
    repeat (6) @(negedge clk);
    check("idle_hi", 64'(hi), 64'd2);
    check("idle_lo", 64'(lo), 64'd14);
    mf_sel = 1'b1;
    #1;
    check("idle_mf_hi", 64'(mf_data), 64'd2);
    mf_req = 1'b1;
    #1;
    check("idle_stall", 64'(stall), 64'd0);
    mf_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
